// File: rtl/serial_addsub_ctrl_pkg.sv
// rtl/serial_addsub_ctrl_pkg.sv - shared types and constants for the serial add/sub controller
package serial_addsub_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD    = 1'b1;
   localparam logic OP_SUB    = 1'b0;
   localparam int   W_DEFAULT = 8;

endpackage

// File: rtl/serial_addsub_ctrl_bit_cell.sv
// rtl/serial_addsub_ctrl_bit_cell.sv - 1-bit add/subtract cell (op1 = sum/diff bit, op2 = carry/borrow out)
module addsub_bit_cell
   import serial_addsub_ctrl_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic en,
   output logic op1,
   output logic op2
);

   assign op1 = a ^ b ^ cin;
   assign op2 = (en == OP_ADD) ? ((a & b) | ((a ^ b) & cin))
                               : ((~a & b) | (~(a ^ b) & cin));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - two-requester bit-serial add/sub controller; SERIAL_ADDSUB_OVF_EN adds rsp_ovf
module serial_addsub_ctrl
   import serial_addsub_ctrl_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req0_en,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic         req1_en,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_res,
   output logic         rsp_cb
`ifdef SERIAL_ADDSUB_OVF_EN
   ,
   output logic         rsp_ovf
`endif
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic           carry;
   logic [W-1:0]   a_sh;
   logic [W-1:0]   b_sh;
   logic [W-1:0]   res;
   logic           en_r;
   logic           id_r;
   logic           ptr;
   logic           gnt_valid;
   logic           gnt_id;
   logic           accept;
   logic           c_op1;
   logic           c_op2;

   // ptr names the requester preferred on contention; it flips away from each winner
   always_comb begin
      gnt_valid = req0_valid | req1_valid;
      gnt_id    = (req0_valid & req1_valid) ? ptr : req1_valid;
      accept    = (state == IDLE) & gnt_valid;
   end

   assign req0_ready = rst_n & accept & ~gnt_id;
   assign req1_ready = rst_n & accept &  gnt_id;

   // Operands shift right so the cell always sees the current bit at index 0
   addsub_bit_cell u_cell (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .cin (carry),
      .en  (en_r),
      .op1 (c_op1),
      .op2 (c_op2)
   );

`ifdef SERIAL_ADDSUB_OVF_EN
   logic ovf_r;
   assign rsp_ovf = ovf_r;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         carry <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
         res   <= '0;
         en_r  <= 1'b0;
         id_r  <= 1'b0;
         ptr   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf_r <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_sh  <= gnt_id ? req1_a  : req0_a;
                  b_sh  <= gnt_id ? req1_b  : req0_b;
                  en_r  <= gnt_id ? req1_en : req0_en;
                  id_r  <= gnt_id;
                  ptr   <= ~gnt_id;
                  carry <= 1'b0;
                  cnt   <= '0;
                  res   <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
                  ovf_r <= 1'b0;
`endif
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               res   <= {c_op1, res[W-1:1]};
               carry <= c_op2;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(W - 1)) begin
`ifdef SERIAL_ADDSUB_OVF_EN
                  // On the MSB step carry holds the carry into the MSB
                  ovf_r <= (en_r == OP_ADD) ? (carry ^ c_op2)
                                            : ((a_sh[0] ^ b_sh[0]) & (c_op1 ^ a_sh[0]));
`endif
                  state <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rsp_valid = (state == DONE);
   assign rsp_res   = res;
   assign rsp_cb    = carry;
   assign rsp_id    = id_r;

endmodule
